// File: rtl/conv_mac_pipe.sv
// Pipelined windowed multiply-accumulate: LANES products per beat, KERNEL_N/LANES beats
// per window, result held under a valid/ready handshake until the consumer takes it.
module conv_mac_pipe #(
    parameter int DATA_W   = 6,
    parameter int KERNEL_N = 25,
    parameter int LANES    = 5,
    parameter int OUT_W    = 18,
    parameter int SIGNED   = 0,
    parameter int RELU     = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_data,
    input  logic [LANES*DATA_W-1:0]   in_kernel,
    input  logic                      clear,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          out_data
);

    localparam int BEATS  = KERNEL_N / LANES;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PROD_W = 2 * DATA_W;

    localparam logic IS_SIGNED = (SIGNED != 0);
    localparam logic DO_RELU   = (SIGNED != 0) && (RELU != 0);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ST_ACC   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_count;
    logic              r_started;
    logic              r_s1Valid;
    logic              r_s1First;
    logic [PROD_W-1:0] r_prod [LANES];
    logic [OUT_W-1:0]  r_acc;

    logic              w_accept;
    logic              w_clearAcc;
    logic [PROD_W-1:0] w_prod [LANES];
    logic [OUT_W-1:0]  w_sum;

    // in_ready stays low for the first edge after reset via r_started
    assign in_ready   = r_started && (r_state == ST_ACC);
    assign out_valid  = (r_state == ST_HOLD);
    assign w_accept   = in_valid && in_ready && !clear;
    assign w_clearAcc = clear && (r_state == ST_ACC);

    // Operands are extended to the product width first so the truncated
    // product is correct for both unsigned and two's-complement inputs.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DATA_W-1:0] w_a;
        logic [DATA_W-1:0] w_b;
        logic [PROD_W-1:0] w_aExt;
        logic [PROD_W-1:0] w_bExt;
        assign w_a       = in_data[i*DATA_W +: DATA_W];
        assign w_b       = in_kernel[i*DATA_W +: DATA_W];
        assign w_aExt    = {{DATA_W{IS_SIGNED & w_a[DATA_W-1]}}, w_a};
        assign w_bExt    = {{DATA_W{IS_SIGNED & w_b[DATA_W-1]}}, w_b};
        assign w_prod[i] = w_aExt * w_bExt;
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sum = w_sum + {{(OUT_W-PROD_W){IS_SIGNED & r_prod[i][PROD_W-1]}}, r_prod[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_ACC;
            r_count   <= '0;
            r_started <= 1'b0;
        end else begin
            r_started <= 1'b1;
            case (r_state)
                ST_ACC: begin
                    if (w_clearAcc) begin
                        r_count <= '0;
                    end else if (w_accept) begin
                        if (r_count == CNT_LAST) begin
                            r_count <= '0;
                            r_state <= ST_FLUSH;
                        end else begin
                            r_count <= r_count + CNT_ONE;
                        end
                    end
                end
                ST_FLUSH: r_state <= ST_HOLD;
                ST_HOLD: begin
                    if (out_ready) begin
                        r_state <= ST_ACC;
                    end
                end
                default: r_state <= ST_ACC;
            endcase
        end
    end

    // A clear blocks acceptance, so the stage-1 slot empties on that edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1Valid <= 1'b0;
            r_s1First <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_prod[i] <= '0;
            end
        end else begin
            r_s1Valid <= w_accept;
            r_s1First <= w_accept && (r_count == '0);
            if (w_accept) begin
                for (int i = 0; i < LANES; i++) begin
                    r_prod[i] <= w_prod[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (r_s1Valid) begin
            r_acc <= r_s1First ? w_sum : (r_acc + w_sum);
        end
    end

    assign out_data = (DO_RELU && r_acc[OUT_W-1]) ? '0 : r_acc;

endmodule

// File: tb/tb_conv_mac_pipe.sv
// Directed bench for conv_mac_pipe: default unsigned instance plus two signed
// instances (RELU off/on) sharing the same stimulus and handshake.
module tb_conv_mac_pipe;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic        clear;
    logic        outReady;
    logic [29:0] inData;
    logic [29:0] inKernel;

    logic        inReady;
    logic        outValid;
    logic [17:0] outData;
    logic        sInReady;
    logic        sOutValid;
    logic [17:0] sOutData;
    logic        rInReady;
    logic        rOutValid;
    logic [17:0] rOutData;

    int checkCount = 0;
    int errorCount = 0;

    conv_mac_pipe dut (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
        .in_data(inData), .in_kernel(inKernel), .clear(clear),
        .out_valid(outValid), .out_ready(outReady), .out_data(outData)
    );

    conv_mac_pipe #(.SIGNED(1), .RELU(0)) dutSigned (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(sInReady),
        .in_data(inData), .in_kernel(inKernel), .clear(clear),
        .out_valid(sOutValid), .out_ready(outReady), .out_data(sOutData)
    );

    conv_mac_pipe #(.SIGNED(1), .RELU(1)) dutRelu (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(rInReady),
        .in_data(inData), .in_kernel(inKernel), .clear(clear),
        .out_valid(rOutValid), .out_ready(outReady), .out_data(rOutData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic logic [29:0] packAll(input logic [5:0] v);
        return {5{v}};
    endfunction

    function automatic logic [29:0] packSeq(input int base);
        logic [29:0] r;
        for (int i = 0; i < 5; i++) begin
            r[i*6 +: 6] = 6'(base + i);
        end
        return r;
    endfunction

    // Presents one beat and returns #1 after the edge that accepted it
    task automatic applyStimulus(input logic [29:0] data, input logic [29:0] kernel);
        int waitCycles;
        waitCycles = 0;
        inData   = data;
        inKernel = kernel;
        inValid  = 1'b1;
        while (!inReady && waitCycles < 50) begin
            @(posedge clk); #1;
            waitCycles++;
        end
        if (!inReady) checkOutput("beatReadyTimeout", 32'(inReady), 32'd1);
        @(posedge clk); #1;
        inValid = 1'b0;
    endtask

    task automatic applyWindow(input logic [5:0] dataVal, input logic [5:0] kernelVal);
        for (int b = 0; b < 5; b++) begin
            applyStimulus(packAll(dataVal), packAll(kernelVal));
        end
    endtask

    task automatic waitValid(input string tag);
        int n;
        n = 0;
        while (!outValid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput({tag, "_valid"}, 32'(outValid), 32'd1);
    endtask

    task automatic handshake(input string tag);
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
        checkOutput({tag, "_hsReady"}, 32'(inReady), 32'd1);
        checkOutput({tag, "_hsValid"}, 32'(outValid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; inValid = 1'b0; clear = 1'b0; outReady = 1'b0;
        inData = '0; inKernel = '0;

        #12;
        checkOutput("rstReady", 32'(inReady), 32'd0);
        checkOutput("rstValid", 32'(outValid), 32'd0);
        checkOutput("rstData", 32'(outData), 32'd0);
        checkOutput("rstCount", 32'(dut.r_count), 32'd0);
        #10 rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("postRstReady", 32'(inReady), 32'd1);
        checkOutput("postRstValid", 32'(outValid), 32'd0);

        // Max values; latency of out_valid measured from the last acceptance
        applyWindow(6'd63, 6'd63);
        checkOutput("t1Flush", 32'(outValid), 32'd0);
        @(posedge clk); #1;
        checkOutput("t1Latency", 32'(outValid), 32'd1);
        checkOutput("t1Data", 32'(outData), 32'd99225);
        checkOutput("t1ReadyLow", 32'(inReady), 32'd0);
        handshake("t1");

        for (int b = 0; b < 5; b++) begin
            applyStimulus(packSeq(b * 5), packAll(6'd1));
            if (b < 4) begin
                repeat ((b % 3) + 1) begin
                    @(posedge clk); #1;
                end
            end
        end
        waitValid("t2");
        checkOutput("t2Data", 32'(outData), 32'd300);
        handshake("t2");

        // Backpressure: result must hold while out_ready stays low
        applyWindow(6'd3, 6'd1);
        waitValid("t3");
        repeat (10) begin
            @(posedge clk); #1;
            checkOutput("t3Stable", 32'(outData), 32'd75);
            checkOutput("t3ReadyLow", 32'(inReady), 32'd0);
            checkOutput("t3ValidHeld", 32'(outValid), 32'd1);
        end
        handshake("t3");
        applyWindow(6'd1, 6'd1);
        waitValid("t3b");
        checkOutput("t3bData", 32'(outData), 32'd25);
        handshake("t3b");

        for (int b = 0; b < 3; b++) begin
            applyStimulus(packAll(6'd63), packAll(6'd63));
        end
        inData = packAll(6'd63); inKernel = packAll(6'd63);
        inValid = 1'b1; clear = 1'b1;
        checkOutput("t4ClearReady", 32'(inReady), 32'd1);
        @(posedge clk); #1;
        clear = 1'b0; inValid = 1'b0;
        checkOutput("t4ClearCount", 32'(dut.r_count), 32'd0);
        applyWindow(6'd1, 6'd1);
        waitValid("t4");
        checkOutput("t4Data", 32'(outData), 32'd25);
        handshake("t4");

        // Asynchronous reset between edges, two beats into a window
        applyStimulus(packAll(6'd63), packAll(6'd63));
        applyStimulus(packAll(6'd63), packAll(6'd63));
        #3 rst = 1'b1;
        #1;
        checkOutput("t5Valid", 32'(outValid), 32'd0);
        checkOutput("t5Ready", 32'(inReady), 32'd0);
        checkOutput("t5Data", 32'(outData), 32'd0);
        checkOutput("t5Count", 32'(dut.r_count), 32'd0);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("t5ReadyBack", 32'(inReady), 32'd1);
        applyWindow(6'd2, 6'd2);
        waitValid("t5");
        checkOutput("t5WindowData", 32'(outData), 32'd100);
        handshake("t5");

        // -32 * 31 across the window: unsigned, signed and clamped views
        applyWindow(6'h20, 6'd31);
        waitValid("t6");
        checkOutput("t6SignedValid", 32'(sOutValid), 32'd1);
        checkOutput("t6ReluValid", 32'(rOutValid), 32'd1);
        checkOutput("t6Unsigned", 32'(outData), 32'd24800);
        checkOutput("t6Signed", 32'(sOutData), 32'h39F20);
        checkOutput("t6Relu", 32'(rOutData), 32'd0);
        handshake("t6");
        checkOutput("t6SignedReady", 32'(sInReady), 32'd1);
        checkOutput("t6ReluReady", 32'(rInReady), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
